// File: rtl/text_mode_pkg.sv
// Shared constants and types for the text-mode display pipeline.
package text_mode_pkg;

  localparam int unsigned COLS           = 80;
  localparam int unsigned ROWS           = 30;
  localparam int unsigned VRAM_WORDS     = 600;
  localparam int unsigned CTRL_WORD_ADDR = 600;
  localparam int unsigned PIPE_LAT       = 5;

  typedef struct packed {
    logic       inv;
    logic [6:0] code;
  } glyph_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  function automatic rgb12_t ctrl_fg(input logic [31:0] ctrl);
    return rgb12_t'(ctrl[24:13]);
  endfunction

  function automatic rgb12_t ctrl_bg(input logic [31:0] ctrl);
    return rgb12_t'(ctrl[12:1]);
  endfunction

endpackage

// File: rtl/text_glyph_fetch_sync_delay.sv
// Fixed-depth shift register with a configurable reset pattern.
module sync_delay #(
  parameter int unsigned             WIDTH     = 3,
  parameter int unsigned             DEPTH     = 5,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '{default: RESET_VAL};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/text_glyph_fetch.sv
// Text-mode fetch: pixel position -> VRAM word -> glyph byte -> font row -> pixel_on,
// with syncs/DE delayed to match and frame-latched colours.
module text_glyph_fetch
  import text_mode_pkg::*;
(
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        vde_in,
  input  logic [31:0] ctrl_reg,
  output logic [9:0]  vram_addr,
  input  logic [31:0] vram_rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pixel_on,
  output logic [11:0] fg_rgb,
  output logic [11:0] bg_rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        vde_out
);

  logic [11:0] char_idx;
  glyph_t      glyph;
  logic [2:0]  sync_e4;

  logic [9:0]  vram_addr_q, vram_addr_d;
  logic [1:0]  bsel_e1_q, bsel_e1_d, bsel_e2_q, bsel_e2_d;
  logic [3:0]  row_e1_q, row_e1_d, row_e2_q, row_e2_d;
  logic [2:0]  col_e1_q, col_e1_d, col_e2_q, col_e2_d;
  logic [2:0]  col_e3_q, col_e3_d, col_e4_q, col_e4_d;
  logic [10:0] font_addr_q, font_addr_d;
  logic        inv_e3_q, inv_e3_d, inv_e4_q, inv_e4_d;
  logic        pixel_on_q, pixel_on_d;
  logic        hsync_out_q, hsync_out_d, vsync_out_q, vsync_out_d;
  logic        vde_out_q, vde_out_d;
  logic        vsync_prev_q, vsync_prev_d;
  rgb12_t      fg_q, fg_d, bg_q, bg_d;

  logic        unused_bits;
  assign unused_bits = ^{drawY[9], ctrl_reg[31:25], ctrl_reg[0]};

  // {hsync, vsync, vde} through E1..E4; E5 is registered alongside pixel_on.
  sync_delay #(
    .WIDTH    (3),
    .DEPTH    (PIPE_LAT - 1),
    .RESET_VAL(3'b110)
  ) u_sync_delay (
    .clk  (pixel_clk),
    .reset(reset),
    .d_in ({hsync_in, vsync_in, vde_in}),
    .d_out(sync_e4)
  );

  always_comb begin
    char_idx    = 12'(drawY[8:4]) * 12'(COLS) + 12'(drawX[9:3]);
    vram_addr_d = vde_in ? char_idx[11:2] : '0;
    bsel_e1_d   = char_idx[1:0];
    row_e1_d    = drawY[3:0];
    col_e1_d    = drawX[2:0];

    bsel_e2_d   = bsel_e1_q;
    row_e2_d    = row_e1_q;
    col_e2_d    = col_e1_q;

    glyph = '0;
    case (bsel_e2_q)
      2'd0: glyph = glyph_t'(vram_rdata[7:0]);
      2'd1: glyph = glyph_t'(vram_rdata[15:8]);
      2'd2: glyph = glyph_t'(vram_rdata[23:16]);
      2'd3: glyph = glyph_t'(vram_rdata[31:24]);
      default: glyph = '0;
    endcase
    font_addr_d = {glyph.code, row_e2_q};
    inv_e3_d    = glyph.inv;
    col_e3_d    = col_e2_q;

    inv_e4_d    = inv_e3_q;
    col_e4_d    = col_e3_q;

    pixel_on_d  = (font_data[3'd7 - col_e4_q] ^ inv_e4_q) & sync_e4[0];
    {hsync_out_d, vsync_out_d, vde_out_d} = sync_e4;

    // Colours change only on the vsync falling edge so a frame never tears.
    vsync_prev_d = vsync_in;
    fg_d = fg_q;
    bg_d = bg_q;
    if (vsync_prev_q && !vsync_in) begin
      fg_d = ctrl_fg(ctrl_reg);
      bg_d = ctrl_bg(ctrl_reg);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vram_addr_q  <= '0;
      bsel_e1_q    <= '0;
      row_e1_q     <= '0;
      col_e1_q     <= '0;
      bsel_e2_q    <= '0;
      row_e2_q     <= '0;
      col_e2_q     <= '0;
      font_addr_q  <= '0;
      inv_e3_q     <= 1'b0;
      col_e3_q     <= '0;
      inv_e4_q     <= 1'b0;
      col_e4_q     <= '0;
      pixel_on_q   <= 1'b0;
      hsync_out_q  <= 1'b1;
      vsync_out_q  <= 1'b1;
      vde_out_q    <= 1'b0;
      vsync_prev_q <= 1'b1;
      fg_q         <= '0;
      bg_q         <= '0;
    end else begin
      vram_addr_q  <= vram_addr_d;
      bsel_e1_q    <= bsel_e1_d;
      row_e1_q     <= row_e1_d;
      col_e1_q     <= col_e1_d;
      bsel_e2_q    <= bsel_e2_d;
      row_e2_q     <= row_e2_d;
      col_e2_q     <= col_e2_d;
      font_addr_q  <= font_addr_d;
      inv_e3_q     <= inv_e3_d;
      col_e3_q     <= col_e3_d;
      inv_e4_q     <= inv_e4_d;
      col_e4_q     <= col_e4_d;
      pixel_on_q   <= pixel_on_d;
      hsync_out_q  <= hsync_out_d;
      vsync_out_q  <= vsync_out_d;
      vde_out_q    <= vde_out_d;
      vsync_prev_q <= vsync_prev_d;
      fg_q         <= fg_d;
      bg_q         <= bg_d;
    end
  end

  assign vram_addr = vram_addr_q;
  assign font_addr = font_addr_q;
  assign pixel_on  = pixel_on_q;
  assign hsync_out = hsync_out_q;
  assign vsync_out = vsync_out_q;
  assign vde_out   = vde_out_q;
  assign fg_rgb    = fg_q;
  assign bg_rgb    = bg_q;

endmodule

// File: tb/tb_text_glyph_fetch.sv
// Scoreboard bench for text_glyph_fetch: driver queues hand-computed expectations
// tagged with their due cycle; a negedge monitor pops and compares them.
module tb_text_glyph_fetch;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic [9:0]  drawX, drawY;
  logic        hsync_in, vsync_in, vde_in;
  logic [31:0] ctrl_reg;
  logic [9:0]  vram_addr;
  logic [31:0] vram_rdata = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic        pixel_on;
  logic [11:0] fg_rgb, bg_rgb;
  logic        hsync_out, vsync_out, vde_out;

  text_glyph_fetch dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .drawX     (drawX),
    .drawY     (drawY),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .vde_in    (vde_in),
    .ctrl_reg  (ctrl_reg),
    .vram_addr (vram_addr),
    .vram_rdata(vram_rdata),
    .font_addr (font_addr),
    .font_data (font_data),
    .pixel_on  (pixel_on),
    .fg_rgb    (fg_rgb),
    .bg_rgb    (bg_rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .vde_out   (vde_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Synchronous-read memory models: data valid one cycle after the address.
  logic [31:0] vram [1024];
  logic [7:0]  rom  [2048];
  always @(posedge pixel_clk) begin
    vram_rdata <= vram[vram_addr];
    font_data  <= rom[font_addr];
  end

  int unsigned cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int unsigned due;
    logic [31:0] val;
  } exp_t;

  exp_t q_va[$], q_fa[$], q_out[$], q_col[$];
  logic [11:0] exp_fg = '0, exp_bg = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic stale(input string name, input int unsigned due, input logic [31:0] exp);
    n_chk++;
    $display("FAIL %s: expected 0x%0h at cyc %0d, not compared until cyc %0d", name, exp, due, cyc);
  endtask

  // Outputs are registered, so negedge sampling is stable against same-edge input drives.
  always @(negedge pixel_clk) begin
    while (q_va.size() != 0 && q_va[0].due <= cyc) begin
      exp_t e;
      e = q_va.pop_front();
      if (e.due < cyc) stale("vram_addr", e.due, e.val);
      else chk("vram_addr", 32'(vram_addr), e.val);
    end
    while (q_fa.size() != 0 && q_fa[0].due <= cyc) begin
      exp_t e;
      e = q_fa.pop_front();
      if (e.due < cyc) stale("font_addr", e.due, e.val);
      else chk("font_addr", 32'(font_addr), e.val);
    end
    while (q_out.size() != 0 && q_out[0].due <= cyc) begin
      exp_t e;
      e = q_out.pop_front();
      if (e.due < cyc) stale("pix_hs_vs_de", e.due, e.val);
      else chk("pix_hs_vs_de", {28'b0, pixel_on, hsync_out, vsync_out, vde_out}, e.val);
    end
    while (q_col.size() != 0 && q_col[0].due <= cyc) begin
      exp_t e;
      e = q_col.pop_front();
      if (e.due < cyc) stale("fg_bg", e.due, e.val);
      else chk("fg_bg", {8'b0, fg_rgb, bg_rgb}, e.val);
    end
  end

  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic vde,
                       input logic hs, input logic vs, input logic [9:0] eva,
                       input logic [10:0] efa, input logic chk_fa, input logic epix);
    drawX    = x;
    drawY    = y;
    vde_in   = vde;
    hsync_in = hs;
    vsync_in = vs;
    q_va.push_back('{cyc + 1, 32'(eva)});
    if (chk_fa) q_fa.push_back('{cyc + 3, 32'(efa)});
    q_out.push_back('{cyc + 5, {28'b0, epix, hs, vs, vde}});
    q_col.push_back('{cyc + 1, {8'b0, exp_fg, exp_bg}});
    @(negedge pixel_clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pixel_on"},  32'(pixel_on),  32'd0);
    chk({tag, "_vde_out"},   32'(vde_out),   32'd0);
    chk({tag, "_hsync_out"}, 32'(hsync_out), 32'd1);
    chk({tag, "_vsync_out"}, 32'(vsync_out), 32'd1);
    chk({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
    chk({tag, "_font_addr"}, 32'(font_addr), 32'd0);
    chk({tag, "_fg_bg"},     {8'b0, fg_rgb, bg_rgb}, 32'd0);
  endtask

  // Outputs for the four cycles after release still come from cleared stages.
  task automatic push_reset_tail();
    for (int unsigned i = 1; i < 5; i++) q_out.push_back('{cyc + i, 32'h6});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q_va.size() + q_fa.size() + q_out.size() + q_col.size()) != 0; i++)
      @(negedge pixel_clk);
    if ((q_va.size() + q_fa.size() + q_out.size() + q_col.size()) != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations still pending, required 0",
               q_va.size() + q_fa.size() + q_out.size() + q_col.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) vram[i] = '0;
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    vram[0]       = 32'h0000_0041;
    vram[1]       = 32'h00B3_2200;
    vram[20]      = 32'hC100_0000;
    vram[599]     = 32'h5A00_0000;
    rom[11'h415]  = 8'h80;
    rom[11'h410]  = 8'h00;
    rom[11'h412]  = 8'h01;
    rom[11'h220]  = 8'h10;
    rom[11'h330]  = 8'hFF;
    rom[11'h5A0]  = 8'h40;
    rom[11'h005]  = 8'hFF;

    reset = 1'b1; drawX = '0; drawY = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; vde_in = 1'b1; ctrl_reg = '0;
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check_reset_state("rst");

    reset = 1'b0;
    push_reset_tail();
    //     x    y    de hs vs  vaddr  faddr  chk pix
    drive(  0,   5, 1, 1, 1,   0, 11'h415, 1, 1);
    drive(  1,   5, 1, 1, 1,   0, 11'h415, 1, 0);
    drive( 24,  16, 1, 1, 1,  20, 11'h410, 1, 1);
    drive(  7,   2, 1, 1, 1,   0, 11'h412, 1, 1);
    drive(  6,   2, 1, 1, 1,   0, 11'h412, 1, 0);
    drive( 40,   0, 1, 1, 1,   1, 11'h220, 1, 0);
    drive( 43,   0, 1, 1, 1,   1, 11'h220, 1, 1);
    drive( 48,   0, 1, 1, 1,   1, 11'h330, 1, 0);
    drive(633, 464, 1, 1, 1, 599, 11'h5A0, 1, 1);
    drive(632, 464, 1, 1, 1, 599, 11'h5A0, 1, 0);
    drive(700,   5, 0, 1, 1,   0, 11'h005, 1, 0);

    for (int i = 0; i < 96; i++) drive(10'(656 + i), 5, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)  drive(10'(752 + i), 5, 0, 1, 1, 0, 0, 0, 0);

    // vsync edge coincides with the ctrl_reg update: the new word is latched.
    ctrl_reg = 32'h01FE_01FE;
    exp_fg = 12'hFF0; exp_bg = 12'h0FF;
    drive(0, 490, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 490, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 490, 0, 1, 1, 0, 0, 0, 0);
    ctrl_reg = 32'h0000_0000;
    for (int i = 0; i < 4; i++) drive(0, 5, 1, 1, 1, 0, 11'h415, 1, 1);
    exp_fg = 12'h000; exp_bg = 12'h000;
    drive(0, 490, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 490, 0, 1, 1, 0, 0, 0, 0);
    ctrl_reg = 32'h1234_5678;
    drive(0, 490, 0, 1, 1, 0, 0, 0, 0);
    exp_fg = 12'h1A2; exp_bg = 12'hB3C;
    drive(0, 490, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 490, 0, 1, 1, 0, 0, 0, 0);
    drain();

    // Mid-frame reset with live pixels at the input.
    reset = 1'b1; drawX = '0; drawY = 10'd5; vde_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge pixel_clk);
    check_reset_state("midrst");
    @(negedge pixel_clk);
    reset = 1'b0;
    exp_fg = '0; exp_bg = '0;
    push_reset_tail();
    for (int i = 0; i < 6; i++) drive(0, 5, 1, 1, 1, 0, 11'h415, 1, 1);
    for (int i = 0; i < 6; i++) drive(700, 5, 0, 1, 1, 0, 0, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
